kij_pass_ctrl: RTL and testbench

Instruction sequencer that drives the 34-bit `inst` bus of `core` for one complete kij pass, in place of hand-scheduled bench stimulus. On `start` it loads one kernel tile into L0 and the PEs, streams the activation tile through L0 into the array, executes, and drains the OFIFO into psum memory at a kij-indexed region. It sits directly upstream of `core`; its `inst` output connects straight to `core.inst`.

---
 rtl/kij_pass_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_kij_pass_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kij_pass_ctrl.sv
// kij_pass_ctrl: sequences the core instruction bus through one kij pass
// (kernel load, activation stream, execute, OFIFO drain into psum memory).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | idle word on inst, waiting for start
// S_W_L0  | read kernel words from xmem into L0 (col+1 cycles)
// S_LOAD  | move kernel words from L0 into the PEs (col cycles)
// S_GAP   | idle settle time before activations (gap_cyc cycles)
// S_A_L0  | read activation vectors from xmem into L0 (len_nij+1 cycles)
// S_EXEC  | stream L0 into the array with execute (len_nij cycles)
// S_DRAIN | wait for ofifo_valid, then read OFIFO and write pmem
module kij_pass_ctrl #(
    parameter int          ROW     = 8,
    parameter int          COL     = 8,
    parameter int          LEN_NIJ = 64,
    parameter int          GAP_CYC = 10,
    parameter logic [10:0] W_BASE  = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    if (ROW < 1 || COL < 1 || LEN_NIJ < 1 || GAP_CYC < 1) begin : g_param_check
        $error("kij_pass_ctrl: all size parameters must be at least 1");
    end

    localparam int CNT_MAX = LEN_NIJ + COL + GAP_CYC + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] W_L0_LAST = CNT_W'(COL);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] A_L0_LAST = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] COL_C     = CNT_W'(COL);
    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(LEN_NIJ);
    localparam logic [10:0]      COL_A     = 11'(COL);
    localparam logic [10:0]      LEN_A     = 11'(LEN_NIJ);

    // CEN_pmem, WEN_pmem, CEN_xmem, WEN_xmem high; everything else low
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_L0,
        S_LOAD,
        S_GAP,
        S_A_L0,
        S_EXEC,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       kij_q, kij_d;
    logic             burst_q, burst_d;
    logic [33:0]      inst_q, inst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [10:0]      cnt_a, kij_a;

    // next state, counter, captured kij and drain burst phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        kij_d   = kij_q;
        burst_d = burst_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_W_L0;
                    kij_d   = kij;
                end
            end
            S_W_L0: if (cnt_q == W_L0_LAST) begin state_d = S_LOAD; cnt_d = '0; end
            S_LOAD: if (cnt_q == LOAD_LAST) begin state_d = S_GAP;  cnt_d = '0; end
            S_GAP:  if (cnt_q == GAP_LAST)  begin state_d = S_A_L0; cnt_d = '0; end
            S_A_L0: if (cnt_q == A_L0_LAST) begin state_d = S_EXEC; cnt_d = '0; end
            S_EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    burst_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // once the burst starts it runs to completion regardless of valid
                if (!burst_q) begin
                    cnt_d = '0;
                    if (ofifo_valid) burst_d = 1'b1;
                end else if (cnt_q == LEN_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    burst_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                burst_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // instruction word for the cycle the next state will occupy
    always_comb begin
        inst_d = IDLE_WORD;
        cnt_a  = 11'(cnt_d);
        kij_a  = 11'(kij_d);
        case (state_d)
            S_W_L0: begin
                if (cnt_d < COL_C) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = W_BASE + kij_a * COL_A + cnt_a;
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_A_L0: begin
                if (cnt_d < LEN_C) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = cnt_a;
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_DRAIN: begin
                if (burst_d) begin
                    if (cnt_d < LEN_C) inst_d[6] = 1'b1;
                    // pmem write trails the matching OFIFO read by one cycle
                    if (cnt_d != '0) begin
                        inst_d[32]    = 1'b0;
                        inst_d[31]    = 1'b0;
                        inst_d[30:20] = kij_a * LEN_A + cnt_a - 11'd1;
                    end
                end
            end
            default: inst_d = IDLE_WORD;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            burst_q <= 1'b0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            burst_q <= burst_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_kij_pass_ctrl.sv
// tb_kij_pass_ctrl: directed passes of kij_pass_ctrl with per-cycle
// instruction word checks against hand-built expected words.
module tb_kij_pass_ctrl;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  kij;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_bad = 0;
    int done_seen = 0;
    int d0;

    kij_pass_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .kij        (kij),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // count done pulses seen at each rising edge
    always @(posedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected instruction word assembled from the field map
    function automatic logic [33:0] mk(input bit xrd, input logic [10:0] ax,
                                       input bit pw, input logic [10:0] ap,
                                       input bit ofrd, input bit l0rd, input bit l0wr,
                                       input bit exe, input bit ld);
        logic [33:0] w;
        w        = '0;
        w[32]    = !pw;
        w[31]    = !pw;
        w[30:20] = pw ? ap : 11'd0;
        w[19]    = !xrd;
        w[18]    = 1'b1;
        w[17:7]  = xrd ? ax : 11'd0;
        w[6]     = ofrd;
        w[3]     = l0rd;
        w[2]     = l0wr;
        w[1]     = exe;
        w[0]     = ld;
        return w;
    endfunction

    // one pass; returns in the done cycle, or one cycle after a mid-EXEC reset
    task automatic run_pass(input logic [3:0] k, input int dwait, input int rst_at, input bit poke);
        logic [10:0] wb;
        logic [10:0] pb;
        wb = 11'h400 + 11'(k) * 11'd8;
        pb = 11'(k) * 11'd64;
        ofifo_valid = (dwait <= 1);
        start = 1'b1;
        kij   = k;
        tick();
        start = 1'b0;
        kij   = ~k;
        for (int i = 0; i < 9; i++) begin
            chk("w_l0", inst, mk(i < 8, wb + 11'(i), 0, 11'd0, 0, 0, i >= 1, 0, 0));
            chk("w_l0_busy", 34'(busy), 34'd1);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk("load", inst, mk(0, 11'd0, 0, 11'd0, 0, 1, 0, 0, 1));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            chk("gap", inst, IDLE_W);
            tick();
        end
        for (int i = 0; i < 65; i++) begin
            chk("a_l0", inst, mk(i < 64, 11'(i), 0, 11'd0, 0, 0, i >= 1, 0, 0));
            if (poke && i == 10) begin start = 1'b1; kij = 4'd7; end
            if (poke && i == 11) begin start = 1'b0; kij = ~k; end
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            chk("exec", inst, mk(0, 11'd0, 0, 11'd0, 0, 1, 0, 1, 0));
            if (i == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_inst", inst, IDLE_W);
                chk("rst_busy", 34'(busy), 34'd0);
                chk("rst_done", 34'(done), 34'd0);
                tick();
                chk("rst_idle", inst, IDLE_W);
                return;
            end
            tick();
        end
        for (int j = 0; j < dwait; j++) begin
            chk("drain_wait", inst, IDLE_W);
            chk("drain_wait_done", 34'(done), 34'd0);
            if (j == dwait - 1) ofifo_valid = 1'b1;
            tick();
        end
        for (int c = 0; c < 65; c++) begin
            chk("drain", inst, mk(0, 11'd0, c >= 1, pb + 11'(c - 1), c < 64, 0, 0, 0, 0));
            if (dwait > 1 && c == 10) ofifo_valid = 1'b0;
            tick();
        end
        chk("done_inst", inst, IDLE_W);
        chk("done_pulse", 34'(done), 34'd1);
        chk("done_busy", 34'(busy), 34'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        kij         = 4'd3;
        ofifo_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_inst", inst, IDLE_W);
            chk("rst_busy", 34'(busy), 34'd0);
            chk("rst_done", 34'(done), 34'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_inst", inst, IDLE_W);

        run_pass(4'd0, 1, -1, 1'b0);
        tick();
        chk("post_done", 34'(done), 34'd0);
        chk("post_inst", inst, IDLE_W);

        // start raised in the done cycle begins the next pass right away
        run_pass(4'd5, 1, -1, 1'b0);
        start = 1'b1;
        kij   = 4'd5;
        tick();
        start = 1'b0;
        chk("restart_inst", inst, mk(1, 11'h428, 0, 11'd0, 0, 0, 0, 0, 0));
        chk("restart_busy", 34'(busy), 34'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("restart_rst", inst, IDLE_W);

        run_pass(4'd3, 20, -1, 1'b0);
        tick();

        run_pass(4'd4, 1, 30, 1'b0);
        run_pass(4'd2, 1, -1, 1'b0);
        tick();

        d0 = done_seen;
        run_pass(4'd1, 1, -1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_poke_idle", inst, IDLE_W);
        end
        chk("one_done", 34'(done_seen - d0), 34'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
